fp8_mult_arbiter: RTL

//  Shares one combinational 8-bit FP multiplier (FPMult: 1s/3e/4m, 5-bit IEEE flags) among N requesters.

---
 rtl/fp8_mult_pkg.sv | 35 +++
 rtl/fp8_mult_arbiter_if.sv | 31 +++
 rtl/FPMult.sv | 88 ++++++++
 rtl/fp8_rr_arbiter.sv | 33 +++
 rtl/fp8_mult_arbiter.sv | 98 +++++++++
 5 files changed

// File: rtl/fp8_mult_pkg.sv
// Shared types and constants for the FP8 (1s/3e/4m, bias 3) multiplier datapath.
//   FP8_W/EXP_W/MAN_W/FLAG_W : field widths
//   FLAG_*                   : bit positions inside the 5-bit exception flag word
package fp8_mult_pkg;

   localparam int unsigned FP8_W    = 8;
   localparam int unsigned EXP_W    = 3;
   localparam int unsigned MAN_W    = 4;
   localparam int unsigned FLAG_W   = 5;
   localparam int unsigned EXP_BIAS = 3;

   // IEEE-style flag ordering: invalid, div-by-zero, overflow, underflow, inexact
   localparam int unsigned FLAG_NV = 4;
   localparam int unsigned FLAG_DZ = 3;
   localparam int unsigned FLAG_OF = 2;
   localparam int unsigned FLAG_UF = 1;
   localparam int unsigned FLAG_NX = 0;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] expo;
      logic [MAN_W-1:0] mant;
   } fp8_t;

   typedef logic [FLAG_W-1:0] fp_flags_t;

   // Operand pair held in the first pipeline stage
   typedef struct packed {
      fp8_t a;
      fp8_t b;
   } op_pair_t;

   localparam fp8_t FP8_QNAN = '{sign: 1'b0, expo: 3'h7, mant: 4'h8};

endpackage

// File: rtl/fp8_mult_arbiter_if.sv
// Request/response bundle between operand sources and the shared FP8 multiplier.
//   req_valid/req_ready : per-port handshake, req_a/req_b port i at [8*i+:8]
//   resp_*              : shared, ID-tagged response channel
interface fp8_mult_arbiter_if #(
   parameter int unsigned N_REQ = 4
);
   import fp8_mult_pkg::*;

   localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*FP8_W-1:0] req_a;
   logic [N_REQ*FP8_W-1:0] req_b;
   logic                   resp_valid;
   logic                   resp_ready;
   logic [ID_W-1:0]        resp_id;
   fp8_t                   resp_result;
   fp_flags_t              resp_flags;

   modport master (
      output req_valid, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_result, resp_flags
   );

   modport slave (
      input  req_valid, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_id, resp_result, resp_flags
   );

endinterface

// File: rtl/FPMult.sv
// Combinational FP8 multiplier, round-to-nearest-even, subnormals supported.
//   a, b   : operands
//   result : product
//   flags  : NV/DZ/OF/UF/NX exception flags
module FPMult
   import fp8_mult_pkg::*;
(
   input  fp8_t      a,
   input  fp8_t      b,
   output fp8_t      result,
   output fp_flags_t flags
);

   logic       sgn, a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;
   logic       lost, g, s, rnd;
   logic [4:0] sa, sb;
   logic [9:0] p, pn, msh;
   logic [2:0] ef;
   logic [6:0] em;
   int         lz, er, sh;

   always_comb begin
      result = '0;
      flags  = '0;
      sgn    = a.sign ^ b.sign;
      a_inf  = (a.expo == 3'h7) && (a.mant == 4'h0);
      b_inf  = (b.expo == 3'h7) && (b.mant == 4'h0);
      a_nan  = (a.expo == 3'h7) && (a.mant != 4'h0);
      b_nan  = (b.expo == 3'h7) && (b.mant != 4'h0);
      a_zero = (a.expo == 3'h0) && (a.mant == 4'h0);
      b_zero = (b.expo == 3'h0) && (b.mant == 4'h0);

      // Significands with hidden bit; subnormals use exponent 1
      sa = {a.expo != 3'h0, a.mant};
      sb = {b.expo != 3'h0, b.mant};
      p  = {5'b0, sa} * {5'b0, sb};

      lz = 0;
      for (int i = 0; i < 10; i++) begin
         if (p[i]) lz = 9 - i;
      end
      pn = p << lz;
      er = int'((a.expo == 3'h0) ? 3'h1 : a.expo) + int'((b.expo == 3'h0) ? 3'h1 : b.expo)
           - int'(EXP_BIAS) + 1 - lz;

      // Denormalise into the subnormal range, keeping a sticky of shifted-out bits
      sh = 0;
      if (er <= 0) begin
         sh = 1 - er;
         ef = 3'h0;
         if (sh > 9) begin
            msh  = '0;
            lost = |pn;
         end else begin
            msh  = pn >> sh;
            lost = |(pn & ((10'd1 << sh) - 10'd1));
         end
      end else begin
         ef   = 3'(er);
         msh  = pn;
         lost = 1'b0;
      end

      g   = msh[4];
      s   = (|msh[3:0]) | lost;
      rnd = g & (s | msh[5]);
      // Rounding carry ripples into the exponent field (subnormal->normal, max->inf)
      em  = {ef, msh[8:5]} + 7'(rnd);

      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
         result           = FP8_QNAN;
         flags[FLAG_NV]   = (a_inf && b_zero) || (a_zero && b_inf);
      end else if (a_inf || b_inf) begin
         result = '{sign: sgn, expo: 3'h7, mant: 4'h0};
      end else if (a_zero || b_zero) begin
         result = '{sign: sgn, expo: 3'h0, mant: 4'h0};
      end else if ((er >= 7) || (em[6:4] == 3'h7)) begin
         result         = '{sign: sgn, expo: 3'h7, mant: 4'h0};
         flags[FLAG_OF] = 1'b1;
         flags[FLAG_NX] = 1'b1;
      end else begin
         result         = {sgn, em};
         flags[FLAG_NX] = g | s;
         flags[FLAG_UF] = (er <= 0) && (g | s);
      end
   end

endmodule

// File: rtl/fp8_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i wins.
//   req_i   : request vector
//   ptr_i   : highest-priority index this cycle
//   grant_o : one-hot grant, idx_o its index, any_o set when something is granted
module fp8_rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [ID_W-1:0]  idx_o,
   output logic             any_o
);

   int unsigned j;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      j       = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         j = (32'(ptr_i) + i) % N_REQ;
         if (!any_o && req_i[j]) begin
            any_o      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/fp8_mult_arbiter.sv
// Shares one FP8 multiplier among N_REQ requesters through a 2-stage pipeline:
// round-robin accept -> operand register (S1) -> FPMult -> result register (S2).
//   clk, rst : clock, synchronous active-high reset
//   bus      : per-port request handshakes and the shared ID-tagged response
//   op_count : completed response handshakes, wraps modulo 2^CNT_W
module fp8_mult_arbiter
   import fp8_mult_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   fp8_mult_arbiter_if.slave  bus,
   output logic [CNT_W-1:0]   op_count
);

   localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic             v1_q, v2_q;
   op_pair_t         s1_q;
   logic [ID_W-1:0]  id1_q, id2_q;
   fp8_t             res_q;
   fp_flags_t        flg_q;
   logic [ID_W-1:0]  rr_ptr_q;
   logic [CNT_W-1:0] cnt_q;

   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  gidx, ptr_d;
   logic             gany, adv1, adv2, accept;
   op_pair_t         op_sel;
   fp8_t             mul_res;
   fp_flags_t        mul_flg;

   fp8_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
      .req_i   (bus.req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant),
      .idx_o   (gidx),
      .any_o   (gany)
   );

   FPMult u_mult (
      .a      (s1_q.a),
      .b      (s1_q.b),
      .result (mul_res),
      .flags  (mul_flg)
   );

   // Stage load enables: a stage may load when empty or when its successor moves
   assign adv2 = !v2_q || bus.resp_ready;
   assign adv1 = !v1_q || adv2;

   assign bus.req_ready = (rst || !adv1) ? '0 : grant;
   assign accept        = gany && adv1 && !rst;

   assign op_sel.a = bus.req_a[FP8_W*32'(gidx) +: FP8_W];
   assign op_sel.b = bus.req_b[FP8_W*32'(gidx) +: FP8_W];
   assign ptr_d    = (32'(gidx) == N_REQ - 1) ? '0 : gidx + ID_W'(1);

   assign bus.resp_valid  = v2_q;
   assign bus.resp_id     = id2_q;
   assign bus.resp_result = res_q;
   assign bus.resp_flags  = flg_q;
   assign op_count        = cnt_q;

   // Pipeline, pointer and counter state
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         s1_q     <= '0;
         id1_q    <= '0;
         id2_q    <= '0;
         res_q    <= '0;
         flg_q    <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (adv1) begin
            v1_q <= accept;
            if (accept) begin
               s1_q  <= op_sel;
               id1_q <= gidx;
            end
         end
         if (adv2) begin
            v2_q  <= v1_q;
            res_q <= mul_res;
            flg_q <= mul_flg;
            id2_q <= id1_q;
         end
         if (accept) rr_ptr_q <= ptr_d;
         if (v2_q && bus.resp_ready) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule
